// File: rtl/tc_operand_loader_if.sv
// Narrow valid/ready beat stream that carries operand matrices A then B
// from the DMA/stream fabric into the tensor-core operand loader.
interface tc_operand_loader_if #(
   parameter int DW_BUS = 64
);
   logic              s_valid;
   logic              s_ready;
   logic [DW_BUS-1:0] s_data;
   logic              s_last;

   modport master (output s_valid, output s_data, output s_last, input  s_ready);
   modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/tc_operand_loader.sv
// Assembles streamed A/B operand beats into flat row-major buses, then
// sequences load_en, a compute_en pulse and the compute wait window.
module tc_operand_loader #(
   parameter int M              = 16,
   parameter int N              = 16,
   parameter int K              = 16,
   parameter int DW_IN          = 8,
   parameter int DW_BUS         = 64,
   parameter int LOAD_CYCLES    = 3,
   parameter int COMPUTE_CYCLES = 40
) (
   input  logic                   clk,
   input  logic                   reset_n,
   tc_operand_loader_if.slave     s,
   output logic [M*K*DW_IN-1:0]   in_a,
   output logic [K*N*DW_IN-1:0]   in_b,
   output logic                   load_en,
   output logic                   compute_en,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int EPB     = DW_BUS / DW_IN;
   localparam int BEATS_A = M * K / EPB;
   localparam int BEATS_B = K * N / EPB;
   localparam int BMAX    = (BEATS_A > BEATS_B) ? BEATS_A : BEATS_B;
   localparam int BCW     = $clog2(BMAX + 1);
   localparam int CMAX    = (LOAD_CYCLES > COMPUTE_CYCLES) ? LOAD_CYCLES : COMPUTE_CYCLES;
   localparam int CCW     = $clog2(CMAX + 1);

   localparam logic [BCW-1:0] LAST_A    = BCW'(BEATS_A - 1);
   localparam logic [BCW-1:0] LAST_B    = BCW'(BEATS_B - 1);
   localparam logic [CCW-1:0] LAST_LOAD = CCW'(LOAD_CYCLES - 1);
   localparam logic [CCW-1:0] LAST_WAIT = CCW'(COMPUTE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RECV_A = 3'd1,
      RECV_B = 3'd2,
      LOAD   = 3'd3,
      START  = 3'd4,
      WAIT   = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [BCW-1:0]         beat_q, beat_d;
   logic [CCW-1:0]         cyc_q, cyc_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [M*K*DW_IN-1:0]   in_a_q;
   logic [K*N*DW_IN-1:0]   in_b_q;
   logic                   ready;
   logic                   accept;
   logic                   wr_a;
   logic                   wr_b;

   assign ready  = (state_q == IDLE) || (state_q == RECV_A) || (state_q == RECV_B);
   assign accept = s.s_valid && ready;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cyc_d   = cyc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      wr_a    = 1'b0;
      wr_b    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               wr_a   = 1'b1;
               busy_d = 1'b1;
               err_d  = 1'b0;
               if (s.s_last) begin
                  // A stray s_last on the opening beat drops the frame at once.
                  err_d  = 1'b1;
                  busy_d = 1'b0;
               end else if (BEATS_A == 1) begin
                  state_d = RECV_B;
                  beat_d  = '0;
               end else begin
                  state_d = RECV_A;
                  beat_d  = BCW'(1);
               end
            end
         end
         RECV_A: begin
            if (accept) begin
               wr_a = 1'b1;
               if (s.s_last) begin
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
                  beat_d  = '0;
               end else if (beat_q == LAST_A) begin
                  state_d = RECV_B;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BCW'(1);
               end
            end
         end
         RECV_B: begin
            if (accept) begin
               wr_b = 1'b1;
               if (beat_q == LAST_B) begin
                  // Missing s_last on the final beat is flagged but tolerated.
                  if (!s.s_last) err_d = 1'b1;
                  state_d = LOAD;
                  beat_d  = '0;
                  cyc_d   = '0;
               end else if (s.s_last) begin
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BCW'(1);
               end
            end
         end
         LOAD: begin
            if (cyc_q == LAST_LOAD) begin
               state_d = START;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CCW'(1);
            end
         end
         START: begin
            state_d = WAIT;
            cyc_d   = '0;
         end
         WAIT: begin
            if (cyc_q == LAST_WAIT) begin
               state_d = IDLE;
               cyc_d   = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cyc_d = cyc_q + CCW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
            cyc_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         cyc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         in_a_q  <= '0;
         in_b_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cyc_q   <= cyc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         // Beat j lands on flat elements j*EPB .. j*EPB+EPB-1.
         if (wr_a) in_a_q[int'(beat_q)*DW_BUS +: DW_BUS] <= s.s_data;
         if (wr_b) in_b_q[int'(beat_q)*DW_BUS +: DW_BUS] <= s.s_data;
      end
   end

   assign s.s_ready  = ready;
   assign in_a       = in_a_q;
   assign in_b       = in_b_q;
   assign load_en    = (state_q == LOAD);
   assign compute_en = (state_q == START);
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_tc_operand_loader.sv
// Bench for tc_operand_loader: streams matrices, checks assembled buses,
// handshake timing relative to the final beat, and framing error handling.
module tb_tc_operand_loader;

   localparam int M              = 16;
   localparam int N              = 16;
   localparam int K              = 16;
   localparam int DW_IN          = 8;
   localparam int DW_BUS         = 64;
   localparam int LOAD_CYCLES    = 3;
   localparam int COMPUTE_CYCLES = 40;
   localparam int EPB            = DW_BUS / DW_IN;
   localparam int BEATS_A        = M * K / EPB;
   localparam int BEATS_B        = K * N / EPB;
   localparam int NBEATS         = BEATS_A + BEATS_B;
   localparam int COMP_AT        = LOAD_CYCLES + 1;
   localparam int DONE_AT        = LOAD_CYCLES + COMPUTE_CYCLES + 2;
   localparam int WINDOW         = DONE_AT + 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [M*K*DW_IN-1:0] in_a;
   logic [K*N*DW_IN-1:0] in_b;
   logic load_en, compute_en, busy, done, err;

   tc_operand_loader_if #(.DW_BUS(DW_BUS)) sif();

   tc_operand_loader #(
      .M(M), .N(N), .K(K), .DW_IN(DW_IN), .DW_BUS(DW_BUS),
      .LOAD_CYCLES(LOAD_CYCLES), .COMPUTE_CYCLES(COMPUTE_CYCLES)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .s          (sif),
      .in_a       (in_a),
      .in_b       (in_b),
      .load_en    (load_en),
      .compute_en (compute_en),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference matrices, row-major: A(i,j) = matA[i*K+j], B(i,j) = matB[i*N+j].
   byte unsigned matA [M*K];
   byte unsigned matB [K*N];

   // Observations from the last schedule watch, k = cycles after the final beat.
   int ld_n, ld_first, ld_last, cp_n, cp_at, dn_n, dn_at;
   logic busy_at_done, busy_before_done;
   int bad_n, bad_idx, bad_act, bad_exp;

   task automatic fill_index();
      for (int i = 0; i < M*K; i++) matA[i] = 8'(i);
      for (int i = 0; i < K*N; i++) matB[i] = 8'(255 - i);
   endtask

   task automatic fill_random();
      for (int i = 0; i < M*K; i++) matA[i] = 8'($urandom);
      for (int i = 0; i < K*N; i++) matB[i] = 8'($urandom);
   endtask

   // Streams the frame; returns 1 ns after the edge that accepted the last beat sent.
   task automatic drive_frame(input int last_at, input bit with_last, input int bubble_pct);
      int w;
      @(posedge clk); #1;
      for (int b = 0; b < NBEATS; b++) begin
         while (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
            sif.s_valid = 1'b0;
            sif.s_last  = 1'b0;
            @(posedge clk); #1;
         end
         sif.s_valid = 1'b1;
         for (int e = 0; e < EPB; e++) begin
            if (b < BEATS_A) sif.s_data[e*DW_IN +: DW_IN] = matA[b*EPB+e];
            else             sif.s_data[e*DW_IN +: DW_IN] = matB[(b-BEATS_A)*EPB+e];
         end
         sif.s_last = (b == last_at) || (b == NBEATS-1 && with_last);
         w = 0;
         @(negedge clk);
         while (!sif.s_ready && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (!sif.s_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout beat=%0d s_ready=%b required 1", b, sif.s_ready);
         end
         @(posedge clk); #1;
         if (b == last_at) break;
      end
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
   endtask

   task automatic watch(input bit stop_at_done);
      ld_n = 0; ld_first = -1; ld_last = -1; cp_n = 0; cp_at = -1; dn_n = 0; dn_at = -1;
      busy_at_done = 1'bx; busy_before_done = 1'bx;
      for (int k = 1; k <= WINDOW; k++) begin
         @(negedge clk);
         if (load_en) begin
            ld_n++;
            if (ld_first < 0) ld_first = k;
            ld_last = k;
         end
         if (compute_en) begin cp_n++; cp_at = k; end
         if (k == DONE_AT - 1) busy_before_done = busy;
         if (done) begin
            dn_n++; dn_at = k; busy_at_done = busy;
            if (stop_at_done) break;
         end
      end
   endtask

   // Counts elements of the assembled bus that differ from the reference matrix.
   function automatic void mat_diff(input bit is_b);
      logic [DW_IN-1:0] a, e;
      int n_el;
      n_el = is_b ? K*N : M*K;
      bad_n = 0; bad_idx = -1; bad_act = 0; bad_exp = 0;
      for (int i = 0; i < n_el; i++) begin
         a = is_b ? in_b[i*DW_IN +: DW_IN] : in_a[i*DW_IN +: DW_IN];
         e = is_b ? matB[i] : matA[i];
         if (a !== e) begin
            if (bad_n == 0) begin bad_idx = i; bad_act = int'(a); bad_exp = int'(e); end
            bad_n++;
         end
      end
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      for (int c = 0; c < 6; c++) begin
         sif.s_valid = c[0];
         sif.s_data  = 64'h0123_4567_89ab_cdef;
         @(negedge clk);
      end
      checks++;
      if (sif.s_ready !== 1'b1) begin
         errors++; $display("FAIL reset_s_ready got %b want 1", sif.s_ready);
      end
      checks++;
      if ({load_en, compute_en, busy, done, err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 00000", {load_en, compute_en, busy, done, err});
      end
      checks++;
      if (in_a !== '0) begin
         errors++; $display("FAIL reset_in_a ones=%0d want 0", $countones(in_a));
      end
      checks++;
      if (in_b !== '0) begin
         errors++; $display("FAIL reset_in_b ones=%0d want 0", $countones(in_b));
      end
      sif.s_valid = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_full_frame();
      fill_index();
      drive_frame(-1, 1'b1, 0);
      watch(1'b0);
      checks++;
      if (ld_n !== LOAD_CYCLES || ld_first !== 1 || ld_last !== LOAD_CYCLES) begin
         errors++;
         $display("FAIL full_load n=%0d first=%0d last=%0d want n=%0d first=1 last=%0d",
                  ld_n, ld_first, ld_last, LOAD_CYCLES, LOAD_CYCLES);
      end
      checks++;
      if (cp_n !== 1 || cp_at !== COMP_AT) begin
         errors++; $display("FAIL full_compute n=%0d at=%0d want n=1 at=%0d", cp_n, cp_at, COMP_AT);
      end
      checks++;
      if (dn_n !== 1 || dn_at !== DONE_AT) begin
         errors++; $display("FAIL full_done n=%0d at=%0d want n=1 at=%0d", dn_n, dn_at, DONE_AT);
      end
      checks++;
      if (busy_before_done !== 1'b1 || busy_at_done !== 1'b0) begin
         errors++;
         $display("FAIL full_busy before=%b at_done=%b want 1 0", busy_before_done, busy_at_done);
      end
      checks++;
      if (in_a[(3*16+5)*8 +: 8] !== 8'h35) begin
         errors++; $display("FAIL full_a_3_5 got %h want 35", in_a[(3*16+5)*8 +: 8]);
      end
      checks++;
      if (in_b[7:0] !== 8'hFF) begin
         errors++; $display("FAIL full_b_0_0 got %h want ff", in_b[7:0]);
      end
      mat_diff(1'b0);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL full_in_a bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
      mat_diff(1'b1);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL full_in_b bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL full_err got %b want 0", err);
      end
   endtask

   task automatic test_backpressure();
      fill_index();
      drive_frame(-1, 1'b1, 50);
      watch(1'b0);
      checks++;
      if (ld_n !== LOAD_CYCLES || ld_first !== 1 || cp_at !== COMP_AT || dn_n !== 1 || dn_at !== DONE_AT) begin
         errors++;
         $display("FAIL bp_sched load=%0d/%0d comp=%0d done=%0d/%0d want %0d/1 %0d 1/%0d",
                  ld_n, ld_first, cp_at, dn_n, dn_at, LOAD_CYCLES, COMP_AT, DONE_AT);
      end
      mat_diff(1'b0);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL bp_in_a bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
      mat_diff(1'b1);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL bp_in_b bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
   endtask

   task automatic test_early_last();
      fill_random();
      drive_frame(10, 1'b1, 0);
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || sif.s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL early_abort err=%b s_ready=%b busy=%b want 1 1 0", err, sif.s_ready, busy);
      end
      watch(1'b0);
      checks++;
      if (ld_n !== 0 || cp_n !== 0 || dn_n !== 0) begin
         errors++;
         $display("FAIL early_no_run load=%0d comp=%0d done=%0d want 0 0 0", ld_n, cp_n, dn_n);
      end
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL early_err_sticky got %b want 1", err);
      end
      fill_random();
      drive_frame(-1, 1'b1, 20);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL early_err_clear got %b want 0", err);
      end
      watch(1'b0);
      checks++;
      if (dn_n !== 1 || dn_at !== DONE_AT) begin
         errors++; $display("FAIL early_recover_done n=%0d at=%0d want 1 %0d", dn_n, dn_at, DONE_AT);
      end
      mat_diff(1'b1);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL early_recover_in_b bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
   endtask

   task automatic test_missing_last();
      fill_random();
      drive_frame(-1, 1'b0, 0);
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL miss_err got %b want 1", err);
      end
      watch(1'b0);
      checks++;
      if (ld_n !== LOAD_CYCLES || ld_first !== 1 || cp_at !== COMP_AT || dn_n !== 1 || dn_at !== DONE_AT) begin
         errors++;
         $display("FAIL miss_sched load=%0d/%0d comp=%0d done=%0d/%0d want %0d/1 %0d 1/%0d",
                  ld_n, ld_first, cp_at, dn_n, dn_at, LOAD_CYCLES, COMP_AT, DONE_AT);
      end
      mat_diff(1'b0);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL miss_in_a bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
   endtask

   task automatic test_reset_during_wait();
      fill_random();
      drive_frame(-1, 1'b1, 0);
      repeat (COMP_AT + 20) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL rstw_busy_pre got %b want 1", busy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({load_en, compute_en, busy, done, err} !== 5'b0 || sif.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstw_ctrl got %b s_ready=%b want 00000 1",
                  {load_en, compute_en, busy, done, err}, sif.s_ready);
      end
      checks++;
      if (in_a !== '0 || in_b !== '0) begin
         errors++;
         $display("FAIL rstw_bus ones_a=%0d ones_b=%0d want 0 0", $countones(in_a), $countones(in_b));
      end
      @(negedge clk);
      reset_n = 1'b1;
      watch(1'b0);
      checks++;
      if (dn_n !== 0 || ld_n !== 0) begin
         errors++; $display("FAIL rstw_no_done done=%0d load=%0d want 0 0", dn_n, ld_n);
      end
      fill_random();
      drive_frame(-1, 1'b1, 30);
      watch(1'b0);
      checks++;
      if (dn_n !== 1 || dn_at !== DONE_AT || cp_at !== COMP_AT) begin
         errors++;
         $display("FAIL rstw_next done=%0d at=%0d comp=%0d want 1 %0d %0d", dn_n, dn_at, cp_at, DONE_AT, COMP_AT);
      end
      mat_diff(1'b0);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL rstw_next_in_a bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
   endtask

   task automatic test_back_to_back();
      fill_random();
      drive_frame(-1, 1'b1, 0);
      watch(1'b1);
      checks++;
      if (dn_n !== 1 || dn_at !== DONE_AT) begin
         errors++; $display("FAIL b2b_first_done n=%0d at=%0d want 1 %0d", dn_n, dn_at, DONE_AT);
      end
      mat_diff(1'b1);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL b2b_first_in_b bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
      fill_random();
      drive_frame(-1, 1'b1, 0);
      watch(1'b0);
      checks++;
      if (ld_n !== LOAD_CYCLES || cp_at !== COMP_AT || dn_n !== 1 || dn_at !== DONE_AT) begin
         errors++;
         $display("FAIL b2b_second_sched load=%0d comp=%0d done=%0d/%0d want %0d %0d 1/%0d",
                  ld_n, cp_at, dn_n, dn_at, LOAD_CYCLES, COMP_AT, DONE_AT);
      end
      mat_diff(1'b0);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL b2b_second_in_a bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
      mat_diff(1'b1);
      checks++;
      if (bad_n !== 0) begin
         errors++;
         $display("FAIL b2b_second_in_b bad=%0d idx=%0d got %h want %h", bad_n, bad_idx, bad_act, bad_exp);
      end
   endtask

   initial begin
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      sif.s_last  = 1'b0;
      test_reset();
      test_full_frame();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_reset_during_wait();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout time=%0t limit=500000", $time);
      $fatal(1, "timeout");
   end

endmodule
